// File: rtl/sub_result_buf.sv
// sub_result_buf: registered two-entry skid buffer behind the SUB datapath.
// It captures {a, b, diff} over a valid/ready handshake. It tags each result
// with a borrow flag (a < b, unsigned) and a zero flag, and keeps a saturating
// count of accepted borrow events.
//
// Optional feature: define SUB_RESULT_SAT_EN to clamp borrowed results to 0
// (floor saturation) instead of storing the wrapped difference.
module sub_result_buf #(
  parameter int DATAWIDTH = 2,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] diff,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_diff,
  output logic                 out_borrow,
  output logic                 out_zero,
  output logic [CNTWIDTH-1:0]  borrow_cnt
);

  localparam logic [CNTWIDTH-1:0] CNT_MAX = {CNTWIDTH{1'b1}};

  // occupancy: 0..2
  logic [1:0]           count_q,       count_d;
  // head entry (drives the outputs)
  logic [DATAWIDTH-1:0] head_diff_q,   head_diff_d;
  logic                 head_borrow_q, head_borrow_d;
  logic                 head_zero_q,   head_zero_d;
  // tail entry (only meaningful when count_q == 2)
  logic [DATAWIDTH-1:0] tail_diff_q,   tail_diff_d;
  logic                 tail_borrow_q, tail_borrow_d;
  logic                 tail_zero_q,   tail_zero_d;
  // saturating borrow event counter
  logic [CNTWIDTH-1:0]  borrow_cnt_q,  borrow_cnt_d;

  logic                 push, pop;
  logic                 new_borrow;
  logic [DATAWIDTH-1:0] new_diff;
  logic                 new_zero;

  // Handshake flags come from the occupancy register only, so in_ready has
  // no combinational path from out_ready.
  assign in_ready   = (count_q != 2'd2);
  assign out_valid  = (count_q != 2'd0);
  assign out_diff   = head_diff_q;
  assign out_borrow = head_borrow_q;
  assign out_zero   = head_zero_q;
  assign borrow_cnt = borrow_cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Build the entry to be stored: borrow from the operands, zero from the
  // value that actually lands in the register (after any clamping).
  always_comb begin
    new_borrow = (a < b);
`ifdef SUB_RESULT_SAT_EN
    new_diff   = new_borrow ? '0 : diff;
`else
    new_diff   = diff;
`endif
    new_zero   = (new_diff == '0);
  end

  // FIFO next-state: occupancy, head/tail movement and the borrow counter.
  always_comb begin
    count_d       = count_q;
    head_diff_d   = head_diff_q;
    head_borrow_d = head_borrow_q;
    head_zero_d   = head_zero_q;
    tail_diff_d   = tail_diff_q;
    tail_borrow_d = tail_borrow_q;
    tail_zero_d   = tail_zero_q;
    borrow_cnt_d  = borrow_cnt_q;

    unique case ({push, pop})
      2'b10: begin
        // push only: fill head when empty, otherwise fill tail
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_diff_d   = new_diff;
          head_borrow_d = new_borrow;
          head_zero_d   = new_zero;
        end else begin
          tail_diff_d   = new_diff;
          tail_borrow_d = new_borrow;
          tail_zero_d   = new_zero;
        end
      end
      2'b01: begin
        // pop only: tail slides to head
        count_d       = count_q - 2'd1;
        head_diff_d   = tail_diff_q;
        head_borrow_d = tail_borrow_q;
        head_zero_d   = tail_zero_q;
      end
      2'b11: begin
        // push+pop only reachable at count 1 (full blocks push): the new
        // entry replaces the head being consumed
        head_diff_d   = new_diff;
        head_borrow_d = new_borrow;
        head_zero_d   = new_zero;
      end
      default: ;
    endcase

    if (push && new_borrow && (borrow_cnt_q != CNT_MAX))
      borrow_cnt_d = borrow_cnt_q + 1'b1;
  end

  // State registers; reset drops all in-flight entries immediately.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q       <= 2'd0;
      head_diff_q   <= '0;
      head_borrow_q <= 1'b0;
      head_zero_q   <= 1'b0;
      tail_diff_q   <= '0;
      tail_borrow_q <= 1'b0;
      tail_zero_q   <= 1'b0;
      borrow_cnt_q  <= '0;
    end else begin
      count_q       <= count_d;
      head_diff_q   <= head_diff_d;
      head_borrow_q <= head_borrow_d;
      head_zero_q   <= head_zero_d;
      tail_diff_q   <= tail_diff_d;
      tail_borrow_q <= tail_borrow_d;
      tail_zero_q   <= tail_zero_d;
      borrow_cnt_q  <= borrow_cnt_d;
    end
  end

endmodule

// File: doc/sub_result_buf.md
Name: sub_result_buf

Overview:
Registered, elastic output stage placed directly downstream of the combinational SUB datapath block. It captures the operands a and b together with SUB's diff through a valid/ready handshake, and holds them in a 2-entry skid buffer. For each result it derives a borrow flag and a zero flag. It also keeps a saturating count of borrow events for the consumer (register file / comparator stage).

Parameters:
DATAWIDTH, 2, width of a, b, diff and out_diff; matches SUB's DATAWIDTH.
CNTWIDTH, 8, width of the borrow event counter.

Ports:
Clk  input  1  rising-edge clock.
Rst  input  1  asynchronous, active-low reset; Rst=0 resets the block immediately.
in_valid  input  1  upstream presents a valid a/b/diff triple.
in_ready  output  1  buffer can accept a triple this cycle.
a  input  DATAWIDTH  minuend as fed to SUB.
b  input  DATAWIDTH  subtrahend as fed to SUB.
diff  input  DATAWIDTH  SUB output, a-b modulo 2^DATAWIDTH.
out_valid  output  1  head entry valid.
out_ready  input  1  downstream accepts head entry.
out_diff  output  DATAWIDTH  head result.
out_borrow  output  1  head result had a<b (unsigned).
out_zero  output  1  head out_diff == 0.
borrow_cnt  output  CNTWIDTH  number of accepted triples with borrow, saturating.

Behaviour:
- Reset (Rst=0, async): both entries invalid; out_valid=0; in_ready=1; out_diff=0; out_borrow=0; out_zero=0; borrow_cnt=0. Any in-flight entries are discarded.
- Transfer rules: an input transfer occurs when in_valid&in_ready at a Clk edge; an output transfer occurs when out_valid&out_ready at a Clk edge.
- Storage: 2-entry FIFO (head, tail) with a 2-bit occupancy count, values 0..2.
- in_ready = (count<2). It is registered-path derived, with no combinational dependence on out_ready.
- out_valid = (count>0). out_diff, out_borrow and out_zero are driven from head registers only (never combinational from inputs).
- Latency: a triple accepted at edge N appears on the outputs after edge N when the buffer was empty, i.e. one cycle.
- Borrow: borrow = (a < b), unsigned compare, computed at acceptance and stored with the entry.
- Zero: zero = (stored out_diff == 0), evaluated on the stored (possibly saturated) value.
- Occupancy transitions:
  - push only: count+1; the new entry goes to head if count was 0, else to tail.
  - pop only: count-1; tail moves to head.
  - push and pop with count=1: the new entry replaces head; count stays 1.
  - push and pop with count=2: cannot occur, because in_ready=0.
  - pop with count=0: cannot occur, because out_valid=0.
- Data stability: while out_valid=1 and out_ready=0, out_diff, out_borrow and out_zero hold stable.
- Counter: borrow_cnt increments by 1 on each accepted triple whose borrow=1.
  - It stops at 2^CNTWIDTH-1; there is no wrap.
  - It is cleared only by reset.
- Consistency: diff is taken as supplied. No check is made that diff == a-b.
- Reset mid-operation: all state clears asynchronously. After Rst deasserts, the first accept can occur at the first Clk edge.

Optional Feature:
Macro SUB_RESULT_SAT_EN.
- Defined: on acceptance, if borrow=1 the stored out_diff is forced to 0 (unsigned saturation at floor); out_zero is then 1. out_borrow still reports 1.
- Not defined: out_diff stores diff unmodified (wrap-around). out_borrow flags the wrap.

Test Plan:
- Reset check: hold Rst=0 with in_valid=1 -> in_ready=1, out_valid=0, outputs 0, borrow_cnt=0. Release Rst -> first accept on next edge.
- Single pass-through, DATAWIDTH=4, out_ready=1: a=9, b=3, diff=6 -> next cycle out_valid=1, out_diff=6, out_borrow=0, out_zero=0.
- Borrow and wrap, DATAWIDTH=4: a=2, b=5, diff=13.
  - Without SUB_RESULT_SAT_EN -> out_diff=13, out_borrow=1, borrow_cnt=1.
  - With SUB_RESULT_SAT_EN -> out_diff=0, out_zero=1, out_borrow=1.
- Backpressure: out_ready=0, push (7,7,0),(8,1,7),(4,1,3) back-to-back.
  - After 2 accepts -> in_ready=0; the third triple is held by upstream.
  - Head holds out_diff=0, out_zero=1, stable.
  - Then out_ready=1 -> outputs 0, 7, 3 in order, no loss or duplication.
- Simultaneous push/pop at count=1: stream 20 random triples with out_ready=1 continuously -> one result per cycle, in order, in_ready never drops.
- Counter saturation: CNTWIDTH=2, accept 5 triples with a<b -> borrow_cnt reads 1, 2, 3, 3, 3. Async Rst pulse mid-stream -> borrow_cnt=0, out_valid=0 immediately.
